// File: rtl/math_sched_pkg.sv
// Shared types and helpers for the math issue scheduler.
//   math_sched_entry_t : one scheduler slot {v, rob, rs1, r1, rs2, r2, dest, psx}
//   wake_match()       : compares a tag against a vector of broadcast ports
// MAX_WAKE bounds the port count wake_match() can scan; callers zero-pad
// unused ports so they never match.
package math_sched_pkg;

  localparam int PRF_TAG_W    = 6;
  localparam int ROB_ID_W     = 5;
  localparam int ISSUE_DATA_W = 18;
  localparam int MAX_WAKE     = 8;

  typedef struct packed {
    logic                 v;
    logic [ROB_ID_W-1:0]  rob;
    logic [PRF_TAG_W-1:0] rs1;
    logic                 r1;
    logic [PRF_TAG_W-1:0] rs2;
    logic                 r2;
    logic [PRF_TAG_W-1:0] dest;
    logic                 psx;
  } math_sched_entry_t;

  function automatic logic wake_match(
    input logic [PRF_TAG_W-1:0]          tag,
    input logic [MAX_WAKE-1:0]           valid,
    input logic [MAX_WAKE*PRF_TAG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < MAX_WAKE; p++) begin
      if (valid[p] && (tags[p*PRF_TAG_W +: PRF_TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/math_sched_select.sv
// Oldest-first picker: find-first-set from bit 0.
//   req   : candidate vector (bit 0 = oldest entry)
//   grant : one-hot of the lowest set request bit
//   idx   : binary index of the granted bit (0 when nothing requested)
//   any   : at least one request present
module math_sched_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req,
  output logic [DEPTH-1:0]         grant,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(DEPTH);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + DEPTH'(1));
  assign any   = |req;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    idx = '0;
    // Scanning downward leaves the lowest set index as the final value.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/math_issue_sched.sv
// Issue scheduler for the integer / packed-SIMD math stage.
// Collapsing queue of renamed micro-ops; entry 0 is the oldest. Each cycle
// the oldest entry with both operands ready is issued and the entries above
// it shift down. Writeback broadcasts set operand-ready bits.
// Optional feature macro: MATH_SCHED_SPEC_WAKE_EN -- a single-cycle (psx=0)
// op wakes its own dest tag as it issues, allowing back-to-back dependents.
// Ports:
//   cpu_clock_i / cpu_resetn_i : clock, synchronous active-low reset
//   flush_i                    : empties the queue, suppresses issue
//   enq_*                      : enqueue request / ready and op payload
//   wake_valid_i / wake_tag_i  : WAKE_PORTS writeback broadcasts
//   issue_data_o / issue_valid_o : {rs2, rs1, 1'b0, rob} and its valid
//   occupancy_o                : registered entry count
module math_issue_sched
  import math_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WAKE_PORTS = 2
) (
  input  logic                            cpu_clock_i,
  input  logic                            cpu_resetn_i,
  input  logic                            flush_i,
  input  logic                            enq_valid_i,
  output logic                            enq_ready_o,
  input  logic [ROB_ID_W-1:0]             enq_rob_i,
  input  logic [PRF_TAG_W-1:0]            enq_rs1_i,
  input  logic [PRF_TAG_W-1:0]            enq_rs2_i,
  input  logic                            enq_rs1_rdy_i,
  input  logic                            enq_rs2_rdy_i,
  input  logic [PRF_TAG_W-1:0]            enq_dest_i,
  input  logic                            enq_psx_i,
  input  logic [WAKE_PORTS-1:0]           wake_valid_i,
  input  logic [PRF_TAG_W*WAKE_PORTS-1:0] wake_tag_i,
  output logic [ISSUE_DATA_W-1:0]         issue_data_o,
  output logic                            issue_valid_o,
  output logic [$clog2(DEPTH):0]          occupancy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  math_sched_entry_t q  [DEPTH];
  math_sched_entry_t qx [DEPTH+1];   // q plus an empty slot above the top
  math_sched_entry_t n  [DEPTH];
  math_sched_entry_t sel_e;
  math_sched_entry_t enq_e;

  logic [CW-1:0]    cnt, cnt_n, wpos;
  logic [DEPTH-1:0] cand, grant, shift;
  logic [IW-1:0]    sel_idx;
  logic             sel_any, issue, enq_acc;

  logic [MAX_WAKE-1:0]           wv;
  logic [MAX_WAKE*PRF_TAG_W-1:0] wt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) cand[i] = q[i].v & q[i].r1 & q[i].r2;
  end

  math_sched_select #(.DEPTH(DEPTH)) u_select (
    .req   (cand),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign sel_e         = q[sel_idx];
  assign issue         = sel_any & ~flush_i & cpu_resetn_i;
  assign issue_valid_o = issue;
  assign issue_data_o  = sel_any ? {sel_e.rs2, sel_e.rs1, 1'b0, sel_e.rob} : '0;

  // Ready comes from the registered count only; a same-cycle issue does not
  // open a slot for the enqueue.
  assign enq_ready_o = cpu_resetn_i & (cnt < CW'(DEPTH));
  assign enq_acc     = enq_valid_i & enq_ready_o;
  assign occupancy_o = cnt;

  // Broadcast vector seen by every entry and by the incoming enqueue.
  always_comb begin
    wv = '0;
    wt = '0;
    wv[WAKE_PORTS-1:0]              = wake_valid_i;
    wt[PRF_TAG_W*WAKE_PORTS-1:0]    = wake_tag_i;
`ifdef MATH_SCHED_SPEC_WAKE_EN
    // Internal port: a single-cycle ALU result is bypassable next cycle.
    wv[WAKE_PORTS]                        = issue & ~sel_e.psx & (sel_e.dest != '0);
    wt[PRF_TAG_W*WAKE_PORTS +: PRF_TAG_W] = sel_e.dest;
`endif
  end

  always_comb begin
    enq_e      = '0;
    enq_e.v    = 1'b1;
    enq_e.rob  = enq_rob_i;
    enq_e.rs1  = enq_rs1_i;
    enq_e.rs2  = enq_rs2_i;
    enq_e.dest = enq_dest_i;
    enq_e.psx  = enq_psx_i;
    // Tag 0 is the hard-wired zero register and never waits.
    enq_e.r1   = enq_rs1_rdy_i | (enq_rs1_i == '0) | wake_match(enq_rs1_i, wv, wt);
    enq_e.r2   = enq_rs2_rdy_i | (enq_rs2_i == '0) | wake_match(enq_rs2_i, wv, wt);
  end

  // shift[i] is set for the granted entry and every entry above it.
  always_comb begin
    shift[0] = grant[0];
    for (int i = 1; i < DEPTH; i++) shift[i] = shift[i-1] | grant[i];
  end

  assign wpos  = issue ? (cnt - CW'(1)) : cnt;
  assign cnt_n = cnt + CW'(enq_acc) - CW'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) qx[i] = q[i];
    qx[DEPTH] = '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: blocking assignments here build each slot step by step in
      // combinational logic; state registers below use non-blocking only.
      n[i] = (issue & shift[i]) ? qx[i+1] : qx[i];
      if (n[i].v) begin
        n[i].r1 = n[i].r1 | wake_match(n[i].rs1, wv, wt);
        n[i].r2 = n[i].r2 | wake_match(n[i].rs2, wv, wt);
      end
      if (enq_acc && (CW'(i) == wpos)) n[i] = enq_e;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_resetn_i || flush_i) begin
      cnt <= '0;
      // NOTE: only the valid bits are reset; payload fields are don't-care
      // while v=0, so the storage array needs no reset.
      for (int i = 0; i < DEPTH; i++) q[i].v <= 1'b0;
    end else begin
      cnt <= cnt_n;
      for (int i = 0; i < DEPTH; i++) q[i] <= n[i];
    end
  end

endmodule

// File: tb/tb_math_issue_sched.sv
// Self-checking bench for math_issue_sched (DEPTH=8, WAKE_PORTS=2).
// Expected issue words are queued when stimulus is driven and compared, in
// order, whenever the DUT asserts issue_valid_o. Cycle-level expectations
// (latency, occupancy, ready) are checked directly in the main sequence.
module tb_math_issue_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [4:0]  enq_rob;
  logic [5:0]  enq_rs1, enq_rs2, enq_dest;
  logic        enq_rs1_rdy, enq_rs2_rdy, enq_psx;
  logic [1:0]  wake_valid;
  logic [11:0] wake_tag;
  logic [17:0] issue_data;
  logic        issue_valid;
  logic [3:0]  occupancy;

  int checks   = 0;
  int failures = 0;
  logic [17:0] sb [$];
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  math_issue_sched #(.DEPTH(8), .WAKE_PORTS(2)) dut (
    .cpu_clock_i   (clk),
    .cpu_resetn_i  (rst_n),
    .flush_i       (flush),
    .enq_valid_i   (enq_valid),
    .enq_ready_o   (enq_ready),
    .enq_rob_i     (enq_rob),
    .enq_rs1_i     (enq_rs1),
    .enq_rs2_i     (enq_rs2),
    .enq_rs1_rdy_i (enq_rs1_rdy),
    .enq_rs2_rdy_i (enq_rs2_rdy),
    .enq_dest_i    (enq_dest),
    .enq_psx_i     (enq_psx),
    .wake_valid_i  (wake_valid),
    .wake_tag_i    (wake_tag),
    .issue_data_o  (issue_data),
    .issue_valid_o (issue_valid),
    .occupancy_o   (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] idata(input int rob, input int rs1, input int rs2);
    return {6'(rs2), 6'(rs1), 1'b0, 5'(rob)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid  = 1'b0;
    wake_valid = 2'b00;
    flush      = 1'b0;
  endtask

  task automatic enq(input int rob, input int rs1, input int r1, input int rs2,
                     input int r2, input int dest, input int psx);
    enq_valid   = 1'b1;
    enq_rob     = 5'(rob);
    enq_rs1     = 6'(rs1);
    enq_rs1_rdy = 1'(r1);
    enq_rs2     = 6'(rs2);
    enq_rs2_rdy = 1'(r2);
    enq_dest    = 6'(dest);
    enq_psx     = 1'(psx);
  endtask

  task automatic wake(input logic [1:0] v, input int t1, input int t0);
    wake_valid = v;
    wake_tag   = {6'(t1), 6'(t0)};
  endtask

  // Scoreboard: every observed issue must be the next expected word.
  always @(negedge clk) begin
    if (mon_en && issue_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) check("issue_data", 32'(issue_data), 32'(sb.pop_front()));
    end
  end

  // A parked dependent stays parked until an external wake of its tag.
  task automatic parked_dependent(input int rob_a, input int rob_b, input int psx_a);
    enq(rob_a, 0, 0, 0, 0, 20, psx_a);
    sb.push_back(idata(rob_a, 0, 0));
    tick();
    enq(rob_b, 20, 0, 0, 0, 0, 0);
    check("dep_a_issue", 32'(issue_valid), 32'(1));
    tick();
    idle();
    check("dep_b_parked", 32'(issue_valid), 32'(0));
    check("dep_b_occ", 32'(occupancy), 32'(1));
    wake(2'b01, 0, 20);
    sb.push_back(idata(rob_b, 20, 0));
    tick();
    idle();
    check("dep_b_after_wake", 32'(issue_valid), 32'(1));
    tick();
    check("dep_occ_empty", 32'(occupancy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    enq(0, 0, 0, 0, 0, 0, 0);
    enq_valid = 1'b0;
    wake_tag  = '0;

    // Reset held: handshake outputs stay low.
    repeat (3) tick();
    check("rst_enq_ready", 32'(enq_ready), 32'(0));
    check("rst_issue_valid", 32'(issue_valid), 32'(0));
    check("rst_occ", 32'(occupancy), 32'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    check("post_rst_ready", 32'(enq_ready), 32'(1));

    // Single ready op; rs2 tag 0 counts as ready.
    enq(3, 5, 1, 0, 0, 0, 0);
    sb.push_back(idata(3, 5, 0));
    check("t1_no_issue_same_cycle", 32'(issue_valid), 32'(0));
    tick();
    idle();
    check("t1_issue_valid", 32'(issue_valid), 32'(1));
    check("t1_issue_word", 32'(issue_data), 32'(18'h00143));
    check("t1_occ1", 32'(occupancy), 32'(1));
    tick();
    check("t1_occ0", 32'(occupancy), 32'(0));
    check("t1_idle_data", 32'(issue_data), 32'(0));

    // Two ops waiting on tag 9: oldest-first after a single wake.
    enq(1, 9, 0, 0, 0, 0, 0);
    tick();
    enq(2, 9, 0, 0, 0, 0, 0);
    tick();
    idle();
    check("t2_waiting", 32'(issue_valid), 32'(0));
    wake(2'b01, 0, 9);
    sb.push_back(idata(1, 9, 0));
    sb.push_back(idata(2, 9, 0));
    check("t2_wake_cycle", 32'(issue_valid), 32'(0));
    tick();
    idle();
    check("t2_first", 32'(issue_valid), 32'(1));
    tick();
    check("t2_second", 32'(issue_valid), 32'(1));
    tick();
    check("t2_occ0", 32'(occupancy), 32'(0));

    // Fill to DEPTH, then issue while full: enqueue stays refused.
    for (int i = 0; i < 8; i++) begin
      enq(10 + i, 40, 0, 41, 0, 0, 0);
      sb.push_back(idata(10 + i, 40, 41));
      tick();
    end
    idle();
    check("t3_full_occ", 32'(occupancy), 32'(8));
    check("t3_full_ready", 32'(enq_ready), 32'(0));
    check("t3_none_ready", 32'(issue_valid), 32'(0));
    wake(2'b11, 41, 40);
    tick();
    idle();
    check("t3_issue_full", 32'(issue_valid), 32'(1));
    enq(31, 0, 1, 0, 1, 0, 0);
    check("t3_ready_same_cycle", 32'(enq_ready), 32'(0));
    tick();
    idle();
    check("t3_occ7", 32'(occupancy), 32'(7));
    check("t3_ready_next", 32'(enq_ready), 32'(1));
    for (int k = 0; k < 7; k++) begin
      check("t3_drain", 32'(issue_valid), 32'(1));
      tick();
    end
    check("t3_occ0", 32'(occupancy), 32'(0));

    // Wake arriving in the enqueue cycle is captured by the new entry.
    enq(4, 0, 0, 12, 0, 0, 0);
    wake(2'b10, 12, 0);
    sb.push_back(idata(4, 0, 12));
    tick();
    idle();
    check("t4_issue", 32'(issue_valid), 32'(1));
    check("t4_occ", 32'(occupancy), 32'(1));
    tick();
    check("t4_occ0", 32'(occupancy), 32'(0));

    // Flush with two ready entries and a concurrent enqueue.
    for (int i = 0; i < 5; i++) begin
      enq(20 + i, (i < 3) ? 30 : 31, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    wake(2'b01, 0, 31);
    tick();
    idle();
    check("t5_occ5", 32'(occupancy), 32'(5));
    check("t5_ready_before_flush", 32'(issue_valid), 32'(1));
    flush = 1'b1;
    enq(25, 0, 1, 0, 1, 0, 0);
    #1;
    check("t5_flush_blocks_issue", 32'(issue_valid), 32'(0));
    tick();
    idle();
    check("t5_occ0", 32'(occupancy), 32'(0));
    wake(2'b11, 31, 30);
    tick();
    idle();
    repeat (2) begin
      check("t5_no_later_issue", 32'(issue_valid), 32'(0));
      tick();
    end

    // Dependent chain through dest tag 20.
`ifdef MATH_SCHED_SPEC_WAKE_EN
    enq(6, 0, 0, 0, 0, 20, 0);
    sb.push_back(idata(6, 0, 0));
    tick();
    enq(7, 20, 0, 0, 0, 0, 0);
    sb.push_back(idata(7, 20, 0));
    check("t6_a_issue", 32'(issue_valid), 32'(1));
    tick();
    idle();
    check("t6_b_back_to_back", 32'(issue_valid), 32'(1));
    tick();
    check("t6_occ0", 32'(occupancy), 32'(0));
    parked_dependent(8, 9, 1);
`else
    parked_dependent(6, 7, 0);
`endif

    tick();
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
